mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit for the pipe_MIPS32 EX stage. Replaces the
//  single-cycle MUL with a width-parametrised multi-cycle engine that supports
//  signed/unsigned MUL and DIV and produces a HI/LO result pair.
//  A start/busy/done handshake lets the pipeline stall while an operation runs.
//  A flush aborts the operation on a taken branch or HALT.
// PARAMETERS
//  WIDTH   32  operand width in bits; HI and LO are WIDTH bits each; must be >= 4
//  CNT_W   $clog2(WIDTH+1)  iteration counter width (derived; do not override)
// PORTS
//  clk          in   1      single system clock; all state updates on the rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      request a new operation; sampled only in IDLE or DONE
//  op           in   2      00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU
//  a            in   WIDTH  multiplicand / dividend
//  b            in   WIDTH  multiplier / divisor
//  flush        in   1      abort the in-flight operation
//  busy         out  1      high while an operation is in RUN; the pipeline stalls on it
//  done         out  1      one-cycle pulse: hi/lo are valid
//  hi           out  WIDTH  product upper half / remainder
//  lo           out  WIDTH  product lower half / quotient
//  div_by_zero  out  1      flag for the last completed DIV/DIVU with b==0; held with hi/lo
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, hi, lo, div_by_zero = 0. Reset mid-RUN drops the
//   operation immediately.
//  FSM states: IDLE, RUN, DONE.
//   IDLE/DONE -> RUN on (start & ~flush): latch op, |a|, |b|, result signs; count=0.
//   RUN -> RUN while count < WIDTH-1: one radix-2 iteration per clock; count++.
//   RUN -> DONE on iteration WIDTH: apply sign fix-up, load hi/lo, pulse done.
//   DONE -> IDLE after one cycle unless start is high, which goes directly to RUN.
//   Any state -> IDLE on flush: hi/lo/div_by_zero unchanged; no done pulse.
//  Latency: start sampled at edge N; done is high in the cycle after edge N+WIDTH.
//   Back-to-back operations need WIDTH+1 clocks each.
//  busy = (state==RUN). start while busy is ignored. start & flush on the same
//   edge: flush wins and the operation is not accepted.
//  MUL: shift-add on magnitudes, giving a 2*WIDTH product {hi,lo}. Signed: negate
//   the product if sign(a)^sign(b). Exact; no overflow.
//  DIV: restoring division on magnitudes. Signed: quotient negated if sign(a)^sign(b),
//   remainder takes the sign of a (truncate toward zero).
//  b==0 (DIV/DIVU): lo=all ones, hi=a, div_by_zero=1. The operation still runs for
//   WIDTH cycles so latency stays constant.
//  Signed MIN/-1: lo=MIN (2^(WIDTH-1)), hi=0, div_by_zero=0.
//  div_by_zero is cleared on completion of any non-faulting operation.
//  hi/lo change only on entry to DONE.
// STRUCTURE
//  Package mips_muldiv_pkg: op encodings (OP_MUL, OP_MULU, OP_DIV, OP_DIVU),
//   state enum {IDLE,RUN,DONE}, and function negate_if(value, cond).
//  Single module; no sub-module. The shared accumulator/shift register pair
//   {acc[WIDTH], q[WIDTH]} serves both MUL and DIV.
//  The pipe_MIPS32 wrapper drives start from the EX-stage decode of MUL/DIV and
//   holds IF/ID on busy.
// TESTING
//  MUL a=3 b=4 -> done at start+33 clocks; lo=0000000C, hi=00000000.
//  MUL a=FFFFFFFD(-3) b=4 -> lo=FFFFFFF4, hi=FFFFFFFF. MULU FFFFFFFF*FFFFFFFF
//   -> hi=FFFFFFFE, lo=00000001.
//  DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 10/3 -> lo=3, hi=1.
//  DIVU a=0000000A b=0 -> lo=FFFFFFFF, hi=0000000A, div_by_zero=1.
//   Next MULU 2*2 clears the flag.
//  DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
//  flush at count=10 -> IDLE next edge, no done, hi/lo keep previous values.
//   start during busy is ignored. rst_n low mid-RUN clears all outputs.
//   Repeat with WIDTH=8: 8'h0F*8'h0F -> {hi,lo}=16'h00E1, latency 9 clocks.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_muldiv_pkg
//  Description : Shared opcodes, FSM state type and sign helper for the
//                iterative multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_muldiv_pkg;

    // Operation encodings; op[0] set means unsigned, op[1] set means divide
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    // Widest operand supported; the sign helper works on a 2*MAX_W container
    localparam int MAX_W = 64;

    typedef logic [2*MAX_W-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement negate when cond is set. Callers zero-extend into the
    // wide container and truncate back; negation is exact modulo 2^k.
    function automatic wide_t negate_if(input wide_t value, input logic cond);
        return cond ? -value : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mips_muldiv_unit
//  Description : Iterative radix-2 multiply/divide engine producing a HI/LO
//                pair. Shift-add multiply and restoring divide on operand
//                magnitudes, one iteration per clock, with sign fix-up on
//                completion. start/busy/done handshake, flush abort.
//                WIDTH must be in the range 4..MAX_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_mag;      // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_res;  // product / quotient sign
    logic               r_neg_rem;  // remainder follows the dividend sign
    logic               r_bzero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;

    logic               w_accept;
    logic               w_last;
    logic               w_is_div;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign w_signed = (op == OP_MUL) || (op == OP_DIV);
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // A new request is only taken when the engine is not running and no abort is pending
    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && start && !flush;
    assign w_last   = (r_count == CNT_W'(WIDTH-1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle start
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_accept ? RUN : IDLE;
            RUN:     w_next_state = flush ? IDLE : (w_last ? DONE : RUN);
            DONE:    w_next_state = w_accept ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    // One radix-2 step on the shared {acc, q} pair
    always_comb begin
        w_mul_sum = {1'b0, r_acc} + {1'b0, r_mag};
        w_diff    = {r_acc, r_q[WIDTH-1]} - {1'b0, r_mag};
        w_acc_nxt = r_acc;
        w_q_nxt   = r_q;
        if (r_is_div) begin
            // Restoring divide: keep the trial difference only if it stayed non-negative
            if (!w_diff[WIDTH]) begin
                w_acc_nxt = w_diff[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift-add multiply: add on LSB of multiplier, then shift right with carry
            if (r_q[0]) begin
                {w_acc_nxt, w_q_nxt} = {w_mul_sum, r_q[WIDTH-1:1]};
            end else begin
                {w_acc_nxt, w_q_nxt} = {1'b0, r_acc, r_q[WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up applied to the result of the final iteration
    always_comb begin
        w_prod_fix = (2*WIDTH)'(negate_if(wide_t'({w_acc_nxt, w_q_nxt}), r_neg_res));
        w_quo_fix  = WIDTH'(negate_if(wide_t'(w_q_nxt), r_neg_res));
        w_rem_fix  = WIDTH'(negate_if(wide_t'(w_acc_nxt), r_neg_rem));
    end

    // Datapath: latch operands on accept, iterate in RUN, load results on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_mag     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_bzero   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dbz     <= 1'b0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_is_div  <= w_is_div;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_bzero   <= (b == '0);
            // Divide shifts the dividend through q; multiply shifts the multiplier
            r_q       <= w_is_div ? w_a_mag : w_b_mag;
            r_mag     <= w_is_div ? w_b_mag : w_a_mag;
        end else if ((r_state == RUN) && !flush) begin
            r_count <= r_count + CNT_W'(1);
            r_acc   <= w_acc_nxt;
            r_q     <= w_q_nxt;
            if (w_last) begin
                if (r_is_div) begin
                    // Zero divisor leaves |a| in acc, so the remainder fix-up restores a
                    r_hi  <= w_rem_fix;
                    r_lo  <= r_bzero ? '1 : w_quo_fix;
                    r_dbz <= r_bzero;
                end else begin
                    {r_hi, r_lo} <= w_prod_fix;
                    r_dbz        <= 1'b0;
                end
            end
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_muldiv_unit
//  Description : Self-checking bench for mips_muldiv_unit (WIDTH 32 and 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic         flush  = 1'b0;
    logic [1:0]   op     = OP_MUL;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    logic         start8 = 1'b0;
    logic         flush8 = 1'b0;
    logic [1:0]   op8    = OP_MUL;
    logic [7:0]   a8     = '0;
    logic [7:0]   b8     = '0;
    logic         busy8, done8, dbz8;
    logic [7:0]   hi8, lo8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    mips_muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
        .div_by_zero(dbz8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic at operand width w
    function automatic void model(input int w, input logic [1:0] o,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output logic edbz);
        logic [63:0] mask, ux, uy, p, rq, rr;
        longint      sx, sy;
        mask = (64'd1 << w) - 64'd1;
        ux   = {32'd0, x} & mask;
        uy   = {32'd0, y} & mask;
        sx   = ux[w-1] ? longint'(ux) - (longint'(1) << w) : longint'(ux);
        sy   = uy[w-1] ? longint'(uy) - (longint'(1) << w) : longint'(uy);
        edbz = 1'b0;
        rq   = '0;
        rr   = '0;
        if (o == OP_MUL || o == OP_MULU) begin
            p   = (o == OP_MUL) ? 64'(sx * sy) : ux * uy;
            rq  = p & mask;
            rr  = (p >> w) & mask;
        end else if (uy == 64'd0) begin
            rq   = mask;
            rr   = ux;
            edbz = 1'b1;
        end else if (o == OP_DIV) begin
            rq = 64'(sx / sy) & mask;
            rr = 64'(sx % sy) & mask;
        end else begin
            rq = (ux / uy) & mask;
            rr = (ux % uy) & mask;
        end
        ehi = rr[31:0];
        elo = rq[31:0];
    endfunction

    // Issue one op at posedge+1 and wait for done; lat = edges from accept to done
    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x, y, ehi, elo;
        logic        edbz;
        string       tag;
    } vec_t;

    initial begin
        vec_t        dv[10];
        int          lat;
        logic [31:0] ehi, elo, phi, plo, x, y;
        logic        edbz, pdbz, saw_done;
        logic [1:0]  o;

        dv[0] = '{OP_MUL,  32'd3,        32'd4,        32'h0,        32'hC,        1'b0, "mul_3x4"};
        dv[1] = '{OP_MUL,  32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0, "mul_m3x4"};
        dv[2] = '{OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "mulu_max"};
        dv[3] = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2"};
        dv[4] = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7_m2"};
        dv[5] = '{OP_DIVU, 32'd10,       32'd3,        32'h1,        32'h3,        1'b0, "divu_10_3"};
        dv[6] = '{OP_DIVU, 32'h0000000A, 32'd0,        32'h0000000A, 32'hFFFFFFFF, 1'b1, "divu_by0"};
        dv[7] = '{OP_MULU, 32'd2,        32'd2,        32'h0,        32'h4,        1'b0, "mulu_clr"};
        dv[8] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, "div_min_m1"};
        dv[9] = '{OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, "div_neg_by0"};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, issued back to back from the DONE cycle
        for (int i = 0; i < 10; i++) begin
            run32(dv[i].o, dv[i].x, dv[i].y, lat);
            chk({dv[i].tag, "_lat"}, 64'(lat), 64'(W));
            chk({dv[i].tag, "_hi"}, 64'(hi), 64'(dv[i].ehi));
            chk({dv[i].tag, "_lo"}, 64'(lo), 64'(dv[i].elo));
            chk({dv[i].tag, "_dbz"}, 64'(div_by_zero), 64'(dv[i].edbz));
        end
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_not_busy", 64'(busy), 64'd0);

        // Flush at count=10: no done, results untouched
        op = OP_MULU; a = 32'd5; b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_flush_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        saw_done = 1'b0;
        repeat (W + 5) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("flush_no_done", 64'(saw_done), 64'd0);
        chk("flush_hi", 64'(hi), 64'(dv[9].ehi));
        chk("flush_lo", 64'(lo), 64'(dv[9].elo));
        chk("flush_dbz", 64'(div_by_zero), 64'(dv[9].edbz));

        // start & flush together: not accepted
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("start_flush_busy", 64'(busy), 64'd0);

        // start while busy is ignored
        op = OP_MULU; a = 32'd7; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (5) begin @(posedge clk); #1; lat++; end
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat++;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("busy_start_lat", 64'(lat), 64'(W));
        chk("busy_start_hi", 64'(hi), 64'd0);
        chk("busy_start_lo", 64'(lo), 64'd63);

        // Asynchronous reset mid-RUN
        @(posedge clk); #1;
        op = OP_MUL; a = 32'h12345; b = 32'hFFFF0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        chk("mid_rst_hi", 64'(hi), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 15));
                2: begin y = 32'hFFFFFFFF; if ($urandom_range(0, 1) == 1) x = 32'h80000000; end
                default: y = $urandom;
            endcase
            model(W, o, x, y, ehi, elo, edbz);
            run32(o, x, y, lat);
            chk("rnd_lat", 64'(lat), 64'(W));
            chk("rnd_hi", 64'(hi), 64'(ehi));
            chk("rnd_lo", 64'(lo), 64'(elo));
            chk("rnd_dbz", 64'(div_by_zero), 64'(edbz));
        end

        // WIDTH = 8 instance
        run8(OP_MULU, 8'h0F, 8'h0F, lat);
        chk("w8_mulu_lat", 64'(lat), 64'd8);
        chk("w8_mulu_hilo", 64'({hi8, lo8}), 64'h00E1);
        phi = '0; plo = '0; pdbz = 1'b0;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = 32'($urandom_range(0, 255));
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            model(8, o, x, y, ehi, elo, edbz);
            run8(o, x[7:0], y[7:0], lat);
            chk("w8_rnd_lat", 64'(lat), 64'd8);
            chk("w8_rnd_hi", 64'(hi8), 64'(ehi));
            chk("w8_rnd_lo", 64'(lo8), 64'(elo));
            chk("w8_rnd_dbz", 64'(dbz8), 64'(edbz));
            phi = ehi; plo = elo; pdbz = edbz;
        end
        @(posedge clk); #1;
        chk("w8_idle_hi", 64'(hi8), 64'(phi));
        chk("w8_idle_lo", 64'(lo8), 64'(plo));
        chk("w8_idle_dbz", 64'(dbz8), 64'(pdbz));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
